// File: rtl/ualink_mac_pkg.sv
// ---------------------------------------------------------------------------
// ualink_mac_pkg
// Shared types and constants for the ualink_turbo64 dot-product engine:
//   - mac_state_e   : engine control states
//   - DEF_*         : default datapath geometry
//   - acc_width_f() : accumulator width from lane width and guard bits
// ---------------------------------------------------------------------------
package ualink_mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mac_state_e;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_LANES      = 4;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_GUARD_BITS = 8;

  // Full-precision lane product plus headroom for summing many of them.
  function automatic int acc_width_f(input int data_width, input int guard_bits);
    return 2 * data_width + guard_bits;
  endfunction

endpackage

// File: rtl/ualink_mac_lane_mult.sv
// ---------------------------------------------------------------------------
// ualink_mac_lane_mult
// Data-capture stage: multiplies LANES operand pairs from two packed words,
// extends each product to ACC_WIDTH and registers the summed result.
// Ports:
//   clk, rst_n      clock / async active-low reset
//   en              capture enable (read data valid this cycle)
//   signed_mode     1 = lanes are two's complement
//   word_a, word_b  packed operand words, lane i at [(i+1)*DW-1 : i*DW]
//   lane_sum_q      registered sum of the extended lane products
// ---------------------------------------------------------------------------
module ualink_mac_lane_mult #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        signed_mode,
  input  logic [DATA_WIDTH*LANES-1:0] word_a,
  input  logic [DATA_WIDTH*LANES-1:0] word_b,
  output logic [ACC_WIDTH-1:0]        lane_sum_q
);

  localparam int PW = 2 * DATA_WIDTH;

  logic [ACC_WIDTH-1:0] prod_ext_s [LANES];
  logic [ACC_WIDTH-1:0] tree_sum_s;
  logic [ACC_WIDTH-1:0] lane_sum_d;

  // Extending both operands to 2*DW by mode and keeping the low 2*DW bits of
  // the product gives the correct signed or unsigned product with one multiplier.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] a_s;
    logic [DATA_WIDTH-1:0] b_s;
    logic [PW-1:0]         a_ext_s;
    logic [PW-1:0]         b_ext_s;
    logic [PW-1:0]         prod_s;
    assign a_s     = word_a[i*DATA_WIDTH +: DATA_WIDTH];
    assign b_s     = word_b[i*DATA_WIDTH +: DATA_WIDTH];
    assign a_ext_s = {{DATA_WIDTH{signed_mode & a_s[DATA_WIDTH-1]}}, a_s};
    assign b_ext_s = {{DATA_WIDTH{signed_mode & b_s[DATA_WIDTH-1]}}, b_s};
    assign prod_s  = a_ext_s * b_ext_s;
    assign prod_ext_s[i] = {{(ACC_WIDTH-PW){signed_mode & prod_s[PW-1]}}, prod_s};
  end

  // Adder tree over all lanes; hold the register when no data is captured.
  always_comb begin
    tree_sum_s = {ACC_WIDTH{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      tree_sum_s = tree_sum_s + prod_ext_s[i];
    end
    if (en) begin
      lane_sum_d = tree_sum_s;
    end else begin
      lane_sum_d = lane_sum_q;
    end
  end

  // Lane-sum pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_sum_q <= {ACC_WIDTH{1'b0}};
    end else begin
      lane_sum_q <= lane_sum_d;
    end
  end

endmodule

// File: rtl/ualink_mac_engine.sv
// ---------------------------------------------------------------------------
// ualink_mac_engine
// Multi-cycle dot-product engine. On start_mac it reads num_words packed words
// from two arrays over port B (one per cycle, addresses wrapping), multiplies
// lane by lane and accumulates into an ACC_WIDTH accumulator. Pipeline:
// address -> read data -> lane-sum register -> accumulate.
// Ports:
//   clk, rst_n                      clock / async active-low reset
//   start_mac, base_addr, num_words,
//   signed_mode                     request, sampled only in IDLE
//   addrb, enb                      registered port-B read address / enable
//   doutb_a, doutb_b                read data, one cycle after enb
//   busy                            operation in progress (through done cycle)
//   mac_result, overflow            result and overflow, loaded for the done cycle
//   status_done                     one-cycle completion pulse
// Build option: UALINK_MAC_SAT_EN enables saturating accumulation with a
// sticky overflow flag; without it the accumulator wraps and overflow is 0.
// ---------------------------------------------------------------------------
module ualink_mac_engine
  import ualink_mac_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LANES      = DEF_LANES,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int GUARD_BITS = DEF_GUARD_BITS
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start_mac,
  input  logic [ADDR_WIDTH-1:0]              base_addr,
  input  logic [ADDR_WIDTH:0]                num_words,
  input  logic                               signed_mode,
  output logic [ADDR_WIDTH-1:0]              addrb,
  output logic                               enb,
  input  logic [DATA_WIDTH*LANES-1:0]        doutb_a,
  input  logic [DATA_WIDTH*LANES-1:0]        doutb_b,
  output logic                               busy,
  output logic [2*DATA_WIDTH+GUARD_BITS-1:0] mac_result,
  output logic                               status_done,
  output logic                               overflow
);

  localparam int ACC_WIDTH = acc_width_f(DATA_WIDTH, GUARD_BITS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ACC_WIDTH-1:0]  ACC_ZERO = {ACC_WIDTH{1'b0}};

  mac_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addrb_q, addrb_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;       // words still to address after the current one
  logic                  enb_q, enb_d;
  logic                  busy_q, busy_d;
  logic                  status_done_q, status_done_d;
  logic                  mode_q, mode_d;
  logic                  rd_valid_q, rd_valid_d;      // doutb_* holds a requested word
  logic                  prod_valid_q, prod_valid_d;  // lane_sum_q holds a fresh sum
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                  sat_q, sat_d;                // sticky overflow of this run
  logic [ACC_WIDTH-1:0]  mac_result_q, mac_result_d;
  logic                  overflow_q, overflow_d;
  logic [ACC_WIDTH-1:0]  lane_sum_q;
  logic [ACC_WIDTH-1:0]  acc_add_s;
  logic                  add_ovf_s;

  ualink_mac_lane_mult #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_lane_mult (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (rd_valid_q),
    .signed_mode (mode_q),
    .word_a      (doutb_a),
    .word_b      (doutb_b),
    .lane_sum_q  (lane_sum_q)
  );

`ifdef UALINK_MAC_SAT_EN
  logic [ACC_WIDTH:0] sum_ext_s;

  // One extra bit of sum exposes overflow; clamp to the mode's limit.
  always_comb begin
    sum_ext_s = {(ACC_WIDTH+1){1'b0}};
    acc_add_s = acc_q;
    add_ovf_s = 1'b0;
    if (mode_q) begin
      sum_ext_s = {acc_q[ACC_WIDTH-1], acc_q} + {lane_sum_q[ACC_WIDTH-1], lane_sum_q};
      if (sum_ext_s[ACC_WIDTH] != sum_ext_s[ACC_WIDTH-1]) begin
        add_ovf_s = 1'b1;
        if (sum_ext_s[ACC_WIDTH]) begin
          acc_add_s = {1'b1, {(ACC_WIDTH-1){1'b0}}};
        end else begin
          acc_add_s = {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
      end else begin
        acc_add_s = sum_ext_s[ACC_WIDTH-1:0];
      end
    end else begin
      sum_ext_s = {1'b0, acc_q} + {1'b0, lane_sum_q};
      if (sum_ext_s[ACC_WIDTH]) begin
        add_ovf_s = 1'b1;
        acc_add_s = {ACC_WIDTH{1'b1}};
      end else begin
        acc_add_s = sum_ext_s[ACC_WIDTH-1:0];
      end
    end
  end
`else
  // Wrapping accumulation; overflow is never reported.
  always_comb begin
    acc_add_s = acc_q + lane_sum_q;
    add_ovf_s = 1'b0;
  end
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_mac) begin
          if (num_words == CNT_ZERO) state_d = DONE;
          else                       state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (rem_q == CNT_ZERO) state_d = DRAIN;
        else                   state_d = ISSUE;
      end
      // Last word has been accumulated once no read data is left in flight.
      DRAIN: begin
        if (rd_valid_q) state_d = DRAIN;
        else            state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered port-B and status outputs.
  always_comb begin
    enb_d         = 1'b0;
    addrb_d       = addrb_q;
    rem_d         = rem_q;
    mode_d        = mode_q;
    busy_d        = (state_d != IDLE);
    status_done_d = (state_d == DONE);
    case (state_q)
      IDLE: begin
        if (start_mac) begin
          addrb_d = base_addr;
          mode_d  = signed_mode;
          rem_d   = num_words - CNT_ONE;
          enb_d   = (num_words != CNT_ZERO);
        end else begin
          enb_d = 1'b0;
        end
      end
      ISSUE: begin
        if (rem_q != CNT_ZERO) begin
          enb_d   = 1'b1;
          addrb_d = addrb_q + ADDR_ONE;  // wraps modulo 2^ADDR_WIDTH
          rem_d   = rem_q - CNT_ONE;
        end else begin
          enb_d = 1'b0;
        end
      end
      default: enb_d = 1'b0;
    endcase
  end

  // Accumulator, valid pipeline and result capture.
  always_comb begin
    rd_valid_d   = enb_q;
    prod_valid_d = rd_valid_q;
    acc_d        = acc_q;
    sat_d        = sat_q;
    mac_result_d = mac_result_q;
    overflow_d   = overflow_q;
    if ((state_q == IDLE) && start_mac) begin
      acc_d = ACC_ZERO;
      sat_d = 1'b0;
    end else if (prod_valid_q && !sat_q) begin
      // Once saturated the accumulator stays at its limit.
      acc_d = acc_add_s;
      sat_d = add_ovf_s;
    end else begin
      acc_d = acc_q;
      sat_d = sat_q;
    end
    // Load on entry to DONE so the final value is visible in the done cycle.
    if ((state_d == DONE) && (state_q != DONE)) begin
      mac_result_d = acc_d;
      overflow_d   = sat_d;
    end else begin
      mac_result_d = mac_result_q;
      overflow_d   = overflow_q;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addrb_q       <= {ADDR_WIDTH{1'b0}};
      rem_q         <= CNT_ZERO;
      enb_q         <= 1'b0;
      busy_q        <= 1'b0;
      status_done_q <= 1'b0;
      mode_q        <= 1'b0;
      rd_valid_q    <= 1'b0;
      prod_valid_q  <= 1'b0;
      acc_q         <= ACC_ZERO;
      sat_q         <= 1'b0;
      mac_result_q  <= ACC_ZERO;
      overflow_q    <= 1'b0;
    end else begin
      addrb_q       <= addrb_d;
      rem_q         <= rem_d;
      enb_q         <= enb_d;
      busy_q        <= busy_d;
      status_done_q <= status_done_d;
      mode_q        <= mode_d;
      rd_valid_q    <= rd_valid_d;
      prod_valid_q  <= prod_valid_d;
      acc_q         <= acc_d;
      sat_q         <= sat_d;
      mac_result_q  <= mac_result_d;
      overflow_q    <= overflow_d;
    end
  end

  assign addrb       = addrb_q;
  assign enb         = enb_q;
  assign busy        = busy_q;
  assign status_done = status_done_q;
  assign mac_result  = mac_result_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_ualink_mac_engine.sv
// ---------------------------------------------------------------------------
// tb_ualink_mac_engine
// Scoreboard bench for ualink_mac_engine with default parameters. The driver
// pushes expected addresses and results (from directed constants or an
// integer-arithmetic reference model); a negedge monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_ualink_mac_engine;

  localparam int AW   = 8;
  localparam int LN   = 4;
  localparam int ACCW = 40;
  localparam int WW   = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start_mac = 1'b0;
  logic [AW-1:0]   base_addr = '0;
  logic [AW:0]     num_words = '0;
  logic            signed_mode = 1'b0;
  logic [AW-1:0]   addrb;
  logic            enb;
  logic [WW-1:0]   doutb_a = '0;
  logic [WW-1:0]   doutb_b = '0;
  logic            busy;
  logic [ACCW-1:0] mac_result;
  logic            status_done;
  logic            overflow;

  logic [WW-1:0] mem_a [256];
  logic [WW-1:0] mem_b [256];

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [AW-1:0] addr;
    int            cyc;
  } addr_exp_t;

  typedef struct {
    logic [ACCW-1:0] res;
    logic            ovf;
    int              cyc;
  } done_exp_t;

  addr_exp_t addr_q[$];
  done_exp_t done_q[$];
  int busy_lo = 1;
  int busy_hi = 0;

  ualink_mac_engine dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_mac   (start_mac),
    .base_addr   (base_addr),
    .num_words   (num_words),
    .signed_mode (signed_mode),
    .addrb       (addrb),
    .enb         (enb),
    .doutb_a     (doutb_a),
    .doutb_b     (doutb_b),
    .busy        (busy),
    .mac_result  (mac_result),
    .status_done (status_done),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memories: data follows enb by one cycle.
  always @(posedge clk) begin
    if (enb) begin
      doutb_a <= mem_a[addrb];
      doutb_b <= mem_b[addrb];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: integer dot product, per-word accumulate, optional clamping.
  function automatic void model(input logic [AW-1:0] base, input int n, input logic sm,
                                output logic [ACCW-1:0] res, output logic ovf);
    longint acc;
    longint maxv;
    longint minv;
    bit     stuck;
    acc   = 0;
    stuck = 0;
    maxv  = sm ? ((longint'(1) << (ACCW - 1)) - 1) : ((longint'(1) << ACCW) - 1);
    minv  = sm ? -(longint'(1) << (ACCW - 1)) : 0;
    for (int k = 0; k < n; k++) begin
      logic [AW-1:0] ad;
      longint        ws;
      ad = base + AW'(k);
      ws = 0;
      for (int i = 0; i < LN; i++) begin
        logic [15:0] a;
        logic [15:0] b;
        a = mem_a[ad][i*16 +: 16];
        b = mem_b[ad][i*16 +: 16];
        if (sm) ws += longint'($signed(a)) * longint'($signed(b));
        else    ws += longint'(a) * longint'(b);
      end
`ifdef UALINK_MAC_SAT_EN
      if (!stuck) begin
        acc += ws;
        if (acc > maxv) begin
          acc = maxv; stuck = 1;
        end else if (acc < minv) begin
          acc = minv; stuck = 1;
        end
      end
`else
      acc += ws;
`endif
    end
    res = acc[ACCW-1:0];
    ovf = stuck;
  endfunction

  // Issue one run at the current negedge; returns at the first cycle a new
  // start may be accepted. glitch>0 pulses an extra start in that cycle.
  task automatic launch(input logic [AW-1:0] base, input int n, input logic sm,
                        input bit use_k, input logic [ACCW-1:0] k_res, input logic k_ovf,
                        input int glitch);
    logic [ACCW-1:0] r;
    logic            o;
    int              c0;
    int              dc;
    addr_exp_t       ae;
    done_exp_t       de;
    c0 = cyc;
    if (use_k) begin
      r = k_res; o = k_ovf;
    end else begin
      model(base, n, sm, r, o);
    end
    dc = (n == 0) ? c0 + 1 : c0 + n + 3;
    for (int k = 0; k < n; k++) begin
      ae.addr = base + AW'(k);
      ae.cyc  = c0 + 1 + k;
      addr_q.push_back(ae);
    end
    de.res = r; de.ovf = o; de.cyc = dc;
    done_q.push_back(de);
    busy_lo = c0 + 1;
    busy_hi = dc;
    base_addr   = base;
    num_words   = (AW+1)'(n);
    signed_mode = sm;
    start_mac   = 1'b1;
    @(negedge clk);
    while (cyc < dc + 1) begin
      start_mac = (glitch != 0) && (cyc == c0 + glitch);
      if (start_mac) begin
        base_addr   = 8'($urandom_range(0, 255));
        num_words   = '0;
        signed_mode = ~sm;
      end
      @(negedge clk);
    end
    start_mac = 1'b0;
  endtask

  // Start an N=8 run and drop reset in its cycle 5.
  task automatic abort_run();
    int        c0;
    addr_exp_t ae;
    c0 = cyc;
    for (int k = 0; k < 5; k++) begin
      ae.addr = 8'h30 + AW'(k);
      ae.cyc  = c0 + 1 + k;
      addr_q.push_back(ae);
    end
    busy_lo = c0 + 1;
    busy_hi = c0 + 5;
    base_addr = 8'h30; num_words = 9'd8; signed_mode = 1'b0; start_mac = 1'b1;
    @(negedge clk);
    start_mac = 1'b0;
    while (cyc < c0 + 5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_enb", 64'(enb), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(status_done), 64'd0);
    check("abort_addrb", 64'(addrb), 64'd0);
    check("abort_result", 64'(mac_result), 64'd0);
    check("abort_ovf", 64'(overflow), 64'd0);
    busy_lo = 1; busy_hi = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Monitor: compare every DUT output event against the scoreboard queues.
  always @(negedge clk) begin
    addr_exp_t ae;
    done_exp_t de;
    check("busy", 64'(busy), 64'(cyc >= busy_lo && cyc <= busy_hi));
    if (enb) begin
      if (addr_q.size() == 0) begin
        check("enb_unexpected", 64'(enb), 64'd0);
      end else begin
        ae = addr_q.pop_front();
        check("addrb", 64'(addrb), 64'(ae.addr));
        check("enb_cycle", 64'(cyc), 64'(ae.cyc));
      end
    end else if (addr_q.size() != 0 && addr_q[0].cyc < cyc) begin
      ae = addr_q.pop_front();
      check("enb_missing", 64'(enb), 64'd1);
    end
    if (status_done) begin
      if (done_q.size() == 0) begin
        check("done_unexpected", 64'(status_done), 64'd0);
      end else begin
        de = done_q.pop_front();
        check("mac_result", 64'(mac_result), 64'(de.res));
        check("overflow", 64'(overflow), 64'(de.ovf));
        check("done_cycle", 64'(cyc), 64'(de.cyc));
      end
    end else if (done_q.size() != 0 && done_q[0].cyc < cyc) begin
      de = done_q.pop_front();
      check("done_missing", 64'(status_done), 64'd1);
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_enb", 64'(enb), 64'd0);
    check("rst_addrb", 64'(addrb), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(status_done), 64'd0);
    check("rst_result", 64'(mac_result), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Unsigned single word: 1*5+2*6+3*7+4*8 = 70
    mem_a[8'h10] = {16'd4, 16'd3, 16'd2, 16'd1};
    mem_b[8'h10] = {16'd8, 16'd7, 16'd6, 16'd5};
    launch(8'h10, 1, 1'b0, 1'b1, 40'd70, 1'b0, 0);

    // Address wrap FE, FF, 00, 01 with all-ones lanes
    for (int i = 0; i < 4; i++) begin
      mem_a[8'hFE + 8'(i)] = {4{16'd1}};
      mem_b[8'hFE + 8'(i)] = {4{16'd1}};
    end
    launch(8'hFE, 4, 1'b0, 1'b1, 40'd16, 1'b0, 0);

    // Signed versus unsigned interpretation of 0xFFFF * 2
    mem_a[8'h40] = {4{16'hFFFF}};
    mem_b[8'h40] = {4{16'h0002}};
    launch(8'h40, 1, 1'b1, 1'b1, 40'hFF_FFFF_FFF8, 1'b0, 0);
    launch(8'h40, 1, 1'b0, 1'b1, 40'd524280, 1'b0, 0);

    // Zero length
    launch(8'h55, 0, 1'b0, 1'b1, 40'd0, 1'b0, 0);

    // Full-range overflow run
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = {4{16'hFFFF}};
      mem_b[i] = {4{16'hFFFF}};
    end
`ifdef UALINK_MAC_SAT_EN
    launch(8'h00, 256, 1'b0, 1'b1, 40'hFF_FFFF_FFFF, 1'b1, 0);
`else
    launch(8'h00, 256, 1'b0, 1'b1, 40'hFF_F800_0400, 1'b0, 0);
`endif

    // Random memory contents for the model-checked runs
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = {$urandom, $urandom};
      mem_b[i] = {$urandom, $urandom};
    end

    // Start pulse in cycle 3 of an N=8 run must be ignored
    launch(8'h20, 8, 1'($urandom_range(0, 1)), 1'b0, 40'd0, 1'b0, 3);

    for (int r = 0; r < 24; r++) begin
      launch(8'($urandom_range(0, 255)), int'($urandom_range(0, 40)),
             1'($urandom_range(0, 1)), 1'b0, 40'd0, 1'b0, 0);
    end

    abort_run();

    for (int r = 0; r < 6; r++) begin
      launch(8'($urandom_range(0, 255)), int'($urandom_range(0, 20)),
             1'($urandom_range(0, 1)), 1'b0, 40'd0, 1'b0, 0);
    end

    repeat (5) @(negedge clk);
    check("addr_queue_left", 64'(addr_q.size()), 64'd0);
    check("done_queue_left", 64'(done_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
